// File: rtl/button_conditioner.sv
// Purpose : synchronise, debounce and edge-detect N_BTN active-low push buttons, with optional auto-repeat.
// Latency : a clean raw edge yields its registered pulse 2+DB_CYC rising CLK edges later.
// Backpress: none; pulses are single-cycle strobes with no ready handshake, consumers must sample every cycle.
//
// Ports:
//   CLK          system clock, all logic on the rising edge
//   RESETN       asynchronous active-low reset
//   BTN_RAW      raw button pins, active-low, asynchronous to CLK
//   BTN_LEVEL    debounced level, active-low, registered
//   BTN_PRESS    1-cycle pulse per accepted press
//   BTN_RELEASE  1-cycle pulse per accepted release
//   BTN_STROBE   1-cycle pulse on press and on each auto-repeat
//   ANY_PRESS    OR of BTN_PRESS in the same cycle
//
// Build option: define BTN_AUTO_REPEAT_EN to build the auto-repeat counters.
// Without it BTN_STROBE equals BTN_PRESS and the RPT_* parameters only feed
// the parameter sanity check.
module button_conditioner #(
  parameter int N_BTN       = 8,
  parameter int DB_CYC      = 20000,
  parameter int RPT_DLY_CYC = 500000,
  parameter int RPT_PER_CYC = 100000
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [N_BTN-1:0] BTN_RAW,
  output logic [N_BTN-1:0] BTN_LEVEL,
  output logic [N_BTN-1:0] BTN_PRESS,
  output logic [N_BTN-1:0] BTN_RELEASE,
  output logic [N_BTN-1:0] BTN_STROBE,
  output logic             ANY_PRESS
);

  if (N_BTN < 1 || DB_CYC < 1 || RPT_DLY_CYC < 1 || RPT_PER_CYC < 1) begin : g_bad_param
    $error("button_conditioner: N_BTN, DB_CYC, RPT_DLY_CYC and RPT_PER_CYC must all be >= 1");
  end

  localparam int DW = $clog2(DB_CYC + 1);
  // Last count value seen in a wait state before the transition is accepted.
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYC - 1);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [DW-1:0]    dcnt_q  [N_BTN];
  logic [DW-1:0]    dcnt_d  [N_BTN];
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;

`ifdef BTN_AUTO_REPEAT_EN
  // When the period exceeds the initial delay, DLY-PER would go negative.
  // Shifting the start value, target and reload by the same offset keeps the
  // reload non-negative; with PER <= DLY the offset is 0 and rcnt starts at 0,
  // fires on reaching RPT_DLY_CYC and reloads to RPT_DLY_CYC-RPT_PER_CYC.
  localparam int RPT_OFS = (RPT_PER_CYC > RPT_DLY_CYC) ? (RPT_PER_CYC - RPT_DLY_CYC) : 0;
  localparam int RPT_TGT = RPT_DLY_CYC + RPT_OFS;
  localparam int RW      = $clog2(RPT_TGT + 1);
  localparam logic [RW-1:0] R_START = RW'(RPT_OFS);
  localparam logic [RW-1:0] R_TGT   = RW'(RPT_TGT);
  localparam logic [RW-1:0] R_RLD   = RW'(RPT_TGT - RPT_PER_CYC);

  logic [RW-1:0]    rcnt_q [N_BTN];
  logic [RW-1:0]    rcnt_d [N_BTN];
  logic [N_BTN-1:0] strobe_q, strobe_d;
  logic [RW-1:0]    rcnt_inc;
`endif

  always_comb begin
    sync1_d = BTN_RAW;
    sync2_d = sync1_q;
  end

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
`ifdef BTN_AUTO_REPEAT_EN
    strobe_d  = '0;
    rcnt_inc  = '0;
`endif
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      dcnt_d[i]  = dcnt_q[i];
`ifdef BTN_AUTO_REPEAT_EN
      rcnt_d[i]  = rcnt_q[i];
`endif
      case (state_q[i])
        ST_IDLE: begin
          if (!sync2_q[i]) begin
            if (DB_CYC == 1) begin
              state_d[i] = ST_HELD;
              level_d[i] = 1'b0;
              press_d[i] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
              rcnt_d[i]  = R_START;
`endif
            end else begin
              state_d[i] = ST_PRESS_WAIT;
              dcnt_d[i]  = DB_ONE;
            end
          end
        end
        ST_PRESS_WAIT: begin
          if (sync2_q[i]) begin
            state_d[i] = ST_IDLE;
            dcnt_d[i]  = '0;
          end else if (dcnt_q[i] == DB_LAST) begin
            state_d[i] = ST_HELD;
            dcnt_d[i]  = '0;
            level_d[i] = 1'b0;
            press_d[i] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
            rcnt_d[i]  = R_START;
`endif
          end else begin
            dcnt_d[i] = dcnt_q[i] + DB_ONE;
          end
        end
        ST_HELD: begin
          if (sync2_q[i]) begin
            if (DB_CYC == 1) begin
              state_d[i]   = ST_IDLE;
              level_d[i]   = 1'b1;
              release_d[i] = 1'b1;
            end else begin
              state_d[i] = ST_RELEASE_WAIT;
              dcnt_d[i]  = DB_ONE;
            end
          end
`ifdef BTN_AUTO_REPEAT_EN
          else begin
            // Repeats only fire while staying in HELD, never on the press edge.
            rcnt_inc = rcnt_q[i] + RW'(1);
            if (rcnt_inc == R_TGT) begin
              strobe_d[i] = 1'b1;
              rcnt_d[i]   = R_RLD;
            end else begin
              rcnt_d[i] = rcnt_inc;
            end
          end
`endif
        end
        ST_RELEASE_WAIT: begin
          // Bounce back to HELD keeps rcnt so repeat timing just pauses.
          if (!sync2_q[i]) begin
            state_d[i] = ST_HELD;
            dcnt_d[i]  = '0;
          end else if (dcnt_q[i] == DB_LAST) begin
            state_d[i]   = ST_IDLE;
            dcnt_d[i]    = '0;
            level_d[i]   = 1'b1;
            release_d[i] = 1'b1;
          end else begin
            dcnt_d[i] = dcnt_q[i] + DB_ONE;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          dcnt_d[i]  = '0;
        end
      endcase
    end
`ifdef BTN_AUTO_REPEAT_EN
    strobe_d = strobe_d | press_d;
`endif
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '1;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= ST_IDLE;
        dcnt_q[i]  <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        dcnt_q[i]  <= dcnt_d[i];
      end
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      strobe_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        rcnt_q[i] <= '0;
      end
    end else begin
      strobe_q <= strobe_d;
      for (int i = 0; i < N_BTN; i++) begin
        rcnt_q[i] <= rcnt_d[i];
      end
    end
  end

  assign BTN_STROBE = strobe_q;
`else
  assign BTN_STROBE = press_q;
`endif

  assign BTN_LEVEL   = level_q;
  assign BTN_PRESS   = press_q;
  assign BTN_RELEASE = release_q;
  assign ANY_PRESS   = |press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Purpose : directed self-checking bench for button_conditioner (N_BTN=4, DB_CYC=4, RPT 20/8).
// Latency : expected pulses sit 6 edges after a raw change applied just after edge 0.
// Backpress: not applicable; every output is sampled 1 time unit after each rising edge.
module tb_button_conditioner;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic [3:0] BTN_RAW;
  logic [3:0] BTN_LEVEL;
  logic [3:0] BTN_PRESS;
  logic [3:0] BTN_RELEASE;
  logic [3:0] BTN_STROBE;
  logic       ANY_PRESS;

  int n_vec = 0;
  int n_bad = 0;

  button_conditioner #(
    .N_BTN(4), .DB_CYC(4), .RPT_DLY_CYC(20), .RPT_PER_CYC(8)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .BTN_RAW(BTN_RAW),
    .BTN_LEVEL(BTN_LEVEL), .BTN_PRESS(BTN_PRESS), .BTN_RELEASE(BTN_RELEASE),
    .BTN_STROBE(BTN_STROBE), .ANY_PRESS(ANY_PRESS)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic test_reset();
    RESETN  = 1'b0;
    BTN_RAW = 4'hF;
    settle(3);
    n_vec++;
    if ({BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_STROBE, ANY_PRESS} !== {4'hF, 4'h0, 4'h0, 4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs got lvl=%b prs=%b rel=%b stb=%b any=%b want lvl=1111 others 0",
               BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_STROBE, ANY_PRESS);
    end
    RESETN = 1'b1;
    settle(3);
    n_vec++;
    if ({BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_STROBE, ANY_PRESS} !== {4'hF, 4'h0, 4'h0, 4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL idle_after_reset got lvl=%b prs=%b rel=%b stb=%b any=%b want lvl=1111 others 0",
               BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_STROBE, ANY_PRESS);
    end
  endtask

  task automatic test_clean_press();
    BTN_RAW[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_vec++;
      if (BTN_PRESS !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
        n_bad++;
        $display("FAIL press_ch0 edge=%0d got %b want %b", k, BTN_PRESS, (k == 6) ? 4'b0001 : 4'b0000);
      end
      n_vec++;
      if (BTN_LEVEL !== ((k >= 6) ? 4'b1110 : 4'b1111)) begin
        n_bad++;
        $display("FAIL level_ch0 edge=%0d got %b want %b", k, BTN_LEVEL, (k >= 6) ? 4'b1110 : 4'b1111);
      end
      n_vec++;
      if (BTN_STROBE !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
        n_bad++;
        $display("FAIL strobe_ch0 edge=%0d got %b want %b", k, BTN_STROBE, (k == 6) ? 4'b0001 : 4'b0000);
      end
    end
    BTN_RAW[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_vec++;
      if (BTN_RELEASE !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
        n_bad++;
        $display("FAIL release_ch0 edge=%0d got %b want %b", k, BTN_RELEASE, (k == 6) ? 4'b0001 : 4'b0000);
      end
      n_vec++;
      if (BTN_LEVEL[0] !== ((k >= 6) ? 1'b1 : 1'b0)) begin
        n_bad++;
        $display("FAIL level_ch0_rel edge=%0d got %b want %b", k, BTN_LEVEL[0], (k >= 6) ? 1'b1 : 1'b0);
      end
    end
  endtask

  task automatic test_glitch();
    BTN_RAW[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_vec++;
      if (BTN_PRESS[1] !== 1'b0 || BTN_LEVEL[1] !== 1'b1) begin
        n_bad++;
        $display("FAIL glitch_ch1 edge=%0d got prs=%b lvl=%b want prs=0 lvl=1", k, BTN_PRESS[1], BTN_LEVEL[1]);
      end
      if (k == 3) BTN_RAW[1] = 1'b1;
    end
  endtask

  task automatic test_auto_repeat();
    logic exp_stb;
    BTN_RAW[2] = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      tick();
`ifdef BTN_AUTO_REPEAT_EN
      exp_stb = (k == 6) || (k >= 26 && k <= 58 && ((k - 26) % 8) == 0);
`else
      exp_stb = (k == 6);
`endif
      n_vec++;
      if (BTN_STROBE[2] !== exp_stb) begin
        n_bad++;
        $display("FAIL strobe_ch2 edge=%0d got %b want %b", k, BTN_STROBE[2], exp_stb);
      end
      n_vec++;
      if (BTN_PRESS[2] !== (k == 6)) begin
        n_bad++;
        $display("FAIL press_ch2 edge=%0d got %b want %b", k, BTN_PRESS[2], (k == 6));
      end
      n_vec++;
      if (BTN_RELEASE[2] !== (k == 66)) begin
        n_bad++;
        $display("FAIL release_ch2 edge=%0d got %b want %b", k, BTN_RELEASE[2], (k == 66));
      end
      if (k == 60) BTN_RAW[2] = 1'b1;
    end
  endtask

  task automatic test_release_bounce();
    BTN_RAW[0] = 1'b0;
    settle(10);
    n_vec++;
    if (BTN_LEVEL[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL bounce_setup_level got %b want 0", BTN_LEVEL[0]);
    end
    BTN_RAW[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_vec++;
      if (BTN_RELEASE[0] !== (k == 13)) begin
        n_bad++;
        $display("FAIL bounce_release edge=%0d got %b want %b", k, BTN_RELEASE[0], (k == 13));
      end
      n_vec++;
      if (BTN_LEVEL[0] !== (k >= 13)) begin
        n_bad++;
        $display("FAIL bounce_level edge=%0d got %b want %b", k, BTN_LEVEL[0], (k >= 13));
      end
      n_vec++;
      if (BTN_PRESS[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL bounce_press edge=%0d got %b want 0", k, BTN_PRESS[0]);
      end
      if (k == 2) BTN_RAW[0] = 1'b0;
      if (k == 7) BTN_RAW[0] = 1'b1;
    end
  endtask

  task automatic test_simultaneous();
    int any_cnt;
    any_cnt = 0;
    BTN_RAW[1] = 1'b0;
    BTN_RAW[3] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (ANY_PRESS === 1'b1) any_cnt++;
      n_vec++;
      if (BTN_PRESS !== ((k == 6) ? 4'b1010 : 4'b0000)) begin
        n_bad++;
        $display("FAIL simul_press edge=%0d got %b want %b", k, BTN_PRESS, (k == 6) ? 4'b1010 : 4'b0000);
      end
      n_vec++;
      if (ANY_PRESS !== (k == 6)) begin
        n_bad++;
        $display("FAIL simul_any edge=%0d got %b want %b", k, ANY_PRESS, (k == 6));
      end
      n_vec++;
      if (BTN_LEVEL !== ((k >= 6) ? 4'b0101 : 4'b1111)) begin
        n_bad++;
        $display("FAIL simul_level edge=%0d got %b want %b", k, BTN_LEVEL, (k >= 6) ? 4'b0101 : 4'b1111);
      end
    end
    n_vec++;
    if (any_cnt !== 1) begin
      n_bad++;
      $display("FAIL simul_any_count got %0d want 1", any_cnt);
    end
    BTN_RAW = 4'hF;
    settle(10);
    n_vec++;
    if (BTN_LEVEL !== 4'hF) begin
      n_bad++;
      $display("FAIL simul_back_idle got %b want 1111", BTN_LEVEL);
    end
  endtask

  task automatic test_reset_mid_debounce();
    BTN_RAW[0] = 1'b0;
    settle(4);
    RESETN = 1'b0;
    #1;
    n_vec++;
    if ({BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_STROBE, ANY_PRESS} !== {4'hF, 4'h0, 4'h0, 4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL midrst_outputs got lvl=%b prs=%b rel=%b stb=%b any=%b want lvl=1111 others 0",
               BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_STROBE, ANY_PRESS);
    end
    for (int k = 5; k <= 7; k++) begin
      tick();
      n_vec++;
      if (BTN_PRESS !== 4'b0000 || BTN_LEVEL !== 4'hF) begin
        n_bad++;
        $display("FAIL midrst_hold edge=%0d got prs=%b lvl=%b want prs=0000 lvl=1111", k, BTN_PRESS, BTN_LEVEL);
      end
    end
    RESETN = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_vec++;
      if (BTN_PRESS !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
        n_bad++;
        $display("FAIL midrst_press edge=%0d got %b want %b", k, BTN_PRESS, (k == 6) ? 4'b0001 : 4'b0000);
      end
      n_vec++;
      if (BTN_LEVEL[0] !== (k < 6)) begin
        n_bad++;
        $display("FAIL midrst_level edge=%0d got %b want %b", k, BTN_LEVEL[0], (k < 6));
      end
    end
    BTN_RAW = 4'hF;
    settle(10);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_auto_repeat();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Multi-channel front-end conditioner for the raw active-low push buttons (alarm mode, set location, up, set alarm, challenge, cancel, min/hour increment). It synchronises, debounces and edge-detects each button, and optionally auto-repeats while a button is held. It sits directly upstream of the watch top level and replaces its ad-hoc falling-edge detectors. Outputs are clean debounced levels plus single-cycle pulses in the CLK domain (1 MHz nominal).

Parameters:
N_BTN, 8, number of independent button channels
DB_CYC, 20000, cycles the synchronised input must stay stable to accept a transition (20 ms at 1 MHz); legal range 1 and up
RPT_DLY_CYC, 500000, cycles from PRESS to the first auto-repeat strobe; legal range 1 and up
RPT_PER_CYC, 100000, cycles between subsequent auto-repeat strobes; legal range 1 and up

Ports:
CLK  input  1  system clock, all logic on rising edge
RESETN  input  1  asynchronous, active-low reset
BTN_RAW  input  N_BTN  raw button pins, active-low (0 = pressed), asynchronous to CLK
BTN_LEVEL  output  N_BTN  debounced level, active-low, registered
BTN_PRESS  output  N_BTN  1-cycle pulse per accepted press
BTN_RELEASE  output  N_BTN  1-cycle pulse per accepted release
BTN_STROBE  output  N_BTN  1-cycle pulse on press and on each auto-repeat
ANY_PRESS  output  1  OR of BTN_PRESS, same cycle

Behaviour:
- Reset (async assert, sync-free deassert): synchronisers = all 1; every channel in IDLE; counters 0; BTN_LEVEL = all 1; BTN_PRESS, BTN_RELEASE, BTN_STROBE, ANY_PRESS = 0.
- Synchroniser: 2 flops per channel; s = second flop; latency 2 cycles.
- Per-channel FSM, channels fully independent. States: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Debounce counter dcnt is clog2(DB_CYC+1) bits.
  - IDLE: if s==0, go to PRESS_WAIT with dcnt=1. If DB_CYC==1, go directly to HELD instead.
  - PRESS_WAIT: if s==1, go to IDLE with no pulse (glitch rejected). Otherwise dcnt++; when dcnt reaches DB_CYC, go to HELD.
  - Entry to HELD: in the same clock edge, BTN_LEVEL<=0, BTN_PRESS<=1, BTN_STROBE<=1, rcnt<=0.
  - HELD: rcnt increments. If s==1, go to RELEASE_WAIT with dcnt=1, or directly to IDLE when DB_CYC==1.
  - RELEASE_WAIT: if s==0, return to HELD with no pulse; rcnt is held (paused), not cleared. When s==1 has been stable for DB_CYC cycles, go to IDLE with BTN_LEVEL<=1 and BTN_RELEASE<=1.
- Latency: a clean raw edge produces its pulse exactly 2+DB_CYC rising edges later. Pulses are registered and high for exactly 1 cycle.
- Auto-repeat (macro enabled): while in HELD, BTN_STROBE pulses when rcnt reaches RPT_DLY_CYC, then every RPT_PER_CYC cycles. rcnt reloads to RPT_DLY_CYC-RPT_PER_CYC after each repeat, so it never overflows for arbitrarily long holds.
- BTN_PRESS and BTN_STROBE coincide on the press edge. A repeat can never coincide with a press.
- Simultaneous presses on several channels give simultaneous pulses; ANY_PRESS is a single 1-cycle pulse.
- A button held through reset release is reported as a press 2+DB_CYC cycles after RESETN rises.
- Reset mid-debounce discards the pending transition; no pulse is emitted.

Optional Feature:
BTN_AUTO_REPEAT_EN.
- Defined: auto-repeat as described above; rcnt logic is instantiated.
- Undefined: BTN_STROBE is identical to BTN_PRESS; rcnt and the RPT_* logic are not built, and the RPT_* parameters are ignored.

Test Plan:
All scenarios use N_BTN=4, DB_CYC=4, RPT_DLY_CYC=20, RPT_PER_CYC=8; edges are counted from the raw change at edge 0.
1. BTN_RAW[0] 1->0 held for 10 cycles -> BTN_PRESS[0]=1 only at edge 6; BTN_LEVEL[0]=0 from edge 6; other channels stay idle.
2. BTN_RAW[1] low for 3 cycles then high -> no BTN_PRESS[1]; BTN_LEVEL[1] stays 1 throughout.
3. Macro defined, BTN_RAW[2] low for 60 cycles -> BTN_STROBE[2] at edges 6, 26, 34, 42, 50, 58; BTN_RELEASE[2] at edge 66. Macro undefined -> BTN_STROBE[2] at edge 6 only.
4. Held ch0 release bounce: raw high 2 cycles, low 5, then high -> no BTN_RELEASE, BTN_LEVEL[0] stays 0 during the bounce; a single BTN_RELEASE[0] occurs 6 edges after the final rise.
5. BTN_RAW[1] and BTN_RAW[3] fall on the same edge -> BTN_PRESS=4'b1010 at edge 6; ANY_PRESS=1 for exactly 1 cycle.
6. RESETN pulsed low at edge 4 of a ch0 press with raw still low -> outputs return to reset values immediately; no press at the original edge 6; BTN_PRESS[0] occurs 6 edges after RESETN rises.
